// File: rtl/jk_bank_if.sv
// Signal bundle for jk_bank: control/data inputs from the master, stored state and flags back.
interface jk_bank_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             chg_clr;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] changed;
   logic             sr_err;
   logic [CNT_W-1:0] act_cnt;

   modport master (
      output en, mode, j, k, load, load_data, chg_clr,
      input  q, qn, changed, sr_err, act_cnt
   );

   modport slave (
      input  en, mode, j, k, load, load_data, chg_clr,
      output q, qn, changed, sr_err, act_cnt
   );
endinterface

// File: rtl/jk_bank.sv
// Bank of WIDTH JK/T/D/SR storage bits with parallel load, sticky change/error flags.
// Optional saturating activity counter enabled by defining JK_BANK_ACT_CNT_EN.
module jk_bank #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic    clk,
   input logic    reset_n,
   jk_bank_if.slave bus
);

   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_changed;
   logic             r_sr_err;

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_diff;
   logic             w_any;
   logic             w_sr_hit;

   always_comb begin
      w_next   = r_q;
      w_sr_hit = 1'b0;
      if (bus.load) begin
         w_next = bus.load_data;
      end else if (bus.en) begin
         for (int i = 0; i < WIDTH; i++) begin
            case (bus.mode)
               MODE_JK: begin
                  case ({bus.j[i], bus.k[i]})
                     2'b01:   w_next[i] = 1'b0;
                     2'b10:   w_next[i] = 1'b1;
                     2'b11:   w_next[i] = ~r_q[i];
                     default: w_next[i] = r_q[i];
                  endcase
               end
               MODE_T:  w_next[i] = r_q[i] ^ bus.j[i];
               MODE_D:  w_next[i] = bus.j[i];
               MODE_SR: begin
                  case ({bus.j[i], bus.k[i]})
                     2'b01:   w_next[i] = 1'b0;
                     2'b10:   w_next[i] = 1'b1;
                     2'b11:   w_sr_hit  = 1'b1;
                     default: w_next[i] = r_q[i];
                  endcase
               end
               default: w_next[i] = r_q[i];
            endcase
         end
      end
   end

   assign w_diff = w_next ^ r_q;
   assign w_any  = |w_diff;

   // Same-cycle events win over chg_clr: a clear restarts the flags from this cycle's events.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q       <= '0;
         r_changed <= '0;
         r_sr_err  <= 1'b0;
      end else begin
         r_q       <= w_next;
         r_changed <= bus.chg_clr ? w_diff : (r_changed | w_diff);
         r_sr_err  <= bus.chg_clr ? w_sr_hit : (r_sr_err | w_sr_hit);
      end
   end

`ifdef JK_BANK_ACT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (bus.chg_clr) begin
         r_cnt <= w_any ? CNT_W'(1) : '0;
      end else if (w_any && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.act_cnt = r_cnt;
`else
   assign bus.act_cnt = '0;
`endif

   assign bus.q       = r_q;
   assign bus.qn      = ~r_q;
   assign bus.changed = r_changed;
   assign bus.sr_err  = r_sr_err;

endmodule

// File: tb/tb_jk_bank.sv
// Self-checking bench for jk_bank (WIDTH=8, CNT_W=3); follows JK_BANK_ACT_CNT_EN for act_cnt expectations.
module tb_jk_bank;
  logic clk;
  logic reset_n;

  jk_bank_if #(.WIDTH(8), .CNT_W(3)) bus ();

  jk_bank #(.WIDTH(8), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state and scoreboard: {q, changed, sr_err, act_cnt}
  logic [7:0]  m_q, m_chg;
  logic        m_err;
  logic [2:0]  m_cnt;
  logic [19:0] exp_q[$];
  logic [19:0] e, got;

`ifdef JK_BANK_ACT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic model_reset();
    m_q = 8'h00; m_chg = 8'h00; m_err = 1'b0; m_cnt = 3'd0;
  endtask

  // Apply one cycle of inputs, push the expected post-edge state, and advance to edge+1.
  task automatic drive(input logic ld, input logic [7:0] ld_d, input logic en,
                       input logic [1:0] md, input logic [7:0] jj, input logic [7:0] kk,
                       input logic clr);
    logic [7:0] nq;
    logic       hit;
    logic       any;
    bus.load = ld; bus.load_data = ld_d; bus.en = en; bus.mode = md;
    bus.j = jj; bus.k = kk; bus.chg_clr = clr;
    nq  = m_q;
    hit = 1'b0;
    if (ld) nq = ld_d;
    else if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (md == 2'b00) begin
          if (jj[i] && kk[i]) nq[i] = ~m_q[i];
          else if (jj[i])     nq[i] = 1'b1;
          else if (kk[i])     nq[i] = 1'b0;
        end else if (md == 2'b01) begin
          if (jj[i]) nq[i] = ~m_q[i];
        end else if (md == 2'b10) begin
          nq[i] = jj[i];
        end else begin
          if (jj[i] && kk[i]) hit = 1'b1;
          else if (jj[i])     nq[i] = 1'b1;
          else if (kk[i])     nq[i] = 1'b0;
        end
      end
    end
    any = (nq != m_q);
    if (clr) begin
      m_chg = nq ^ m_q;
      m_err = hit;
      m_cnt = any ? 3'd1 : 3'd0;
    end else begin
      m_chg = m_chg | (nq ^ m_q);
      m_err = m_err | hit;
      if (any && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
    end
    if (!CNT_ON) m_cnt = 3'd0;
    m_q = nq;
    exp_q.push_back({m_q, m_chg, m_err, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.load = 0; bus.load_data = 0; bus.en = 0; bus.mode = 0;
    bus.j = 0; bus.k = 0; bus.chg_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (bus.q !== 8'h00) $display("FAIL reset_q: got %h exp 00", bus.q); else n_pass++;
    n_total++; if (bus.qn !== 8'hFF) $display("FAIL reset_qn: got %h exp ff", bus.qn); else n_pass++;
    n_total++; if (bus.changed !== 8'h00 || bus.sr_err !== 1'b0)
      $display("FAIL reset_flags: got chg=%h err=%b exp 00/0", bus.changed, bus.sr_err); else n_pass++;
    n_total++; if (bus.act_cnt !== 3'd0) $display("FAIL reset_cnt: got %0d exp 0", bus.act_cnt); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_jk();
    drive(1, 8'h0F, 0, 2'b00, 8'h00, 8'h00, 1);
    drive(0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 1);
    drive(0, 8'h00, 1, 2'b00, 8'hF0, 8'h3C, 0);
    repeat (2) begin
      e = exp_q.pop_front();
      n_total++; if (1) begin end
      n_total--;
    end
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL jk_sb: got %h exp %h", got, e); else n_pass++;
    n_total++; if (bus.q !== 8'hF3 || bus.qn !== 8'h0C)
      $display("FAIL jk_q: got q=%h qn=%h exp f3/0c", bus.q, bus.qn); else n_pass++;
    n_total++; if (bus.changed !== 8'hFC) $display("FAIL jk_changed: got %h exp fc", bus.changed); else n_pass++;
    n_total++; if (bus.act_cnt !== (CNT_ON ? 3'd1 : 3'd0))
      $display("FAIL jk_cnt: got %0d exp %0d", bus.act_cnt, CNT_ON ? 1 : 0); else n_pass++;
  endtask

  task automatic test_priority();
    logic [2:0] cnt0;
    drive(1, 8'h5A, 1, 2'b00, 8'hFF, 8'hFF, 0);
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL prio_sb: got %h exp %h", got, e); else n_pass++;
    n_total++; if (bus.q !== 8'h5A) $display("FAIL prio_load: got %h exp 5a", bus.q); else n_pass++;
    cnt0 = m_cnt;
    for (int c = 0; c < 3; c++) begin
      drive(0, 8'($urandom), 0, 2'($urandom), 8'($urandom), 8'($urandom), 0);
      e = exp_q.pop_front();
      got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
      n_total++; if (got !== e) $display("FAIL prio_hold_sb: got %h exp %h", got, e); else n_pass++;
    end
    n_total++; if (bus.q !== 8'h5A || bus.act_cnt !== cnt0)
      $display("FAIL prio_hold: got q=%h cnt=%0d exp 5a/%0d", bus.q, bus.act_cnt, cnt0); else n_pass++;
  endtask

  task automatic test_sr_err();
    drive(1, 8'h00, 0, 2'b11, 8'h00, 8'h00, 1);
    drive(0, 8'h00, 0, 2'b11, 8'h00, 8'h00, 1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    drive(0, 8'h00, 1, 2'b11, 8'h03, 8'h01, 0);
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL sr_sb: got %h exp %h", got, e); else n_pass++;
    n_total++; if (bus.q !== 8'h02 || bus.sr_err !== 1'b1)
      $display("FAIL sr_err_set: got q=%h err=%b exp 02/1", bus.q, bus.sr_err); else n_pass++;
    drive(0, 8'h00, 0, 2'b11, 8'h03, 8'h03, 1);
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL sr_clr_sb: got %h exp %h", got, e); else n_pass++;
    n_total++; if (bus.sr_err !== 1'b0 || bus.changed !== 8'h00 || bus.act_cnt !== 3'd0)
      $display("FAIL sr_clr: got err=%b chg=%h cnt=%0d exp 0/00/0", bus.sr_err, bus.changed, bus.act_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    drive(1, 8'h00, 0, 2'b01, 8'h00, 8'h00, 1);
    drive(0, 8'h00, 0, 2'b01, 8'h00, 8'h00, 1);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    for (int c = 0; c < 10; c++) begin
      drive(0, 8'h00, 1, 2'b01, 8'h01, 8'($urandom), 0);
      e = exp_q.pop_front();
      got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
      n_total++; if (got !== e) $display("FAIL sat_sb[%0d]: got %h exp %h", c, got, e); else n_pass++;
    end
    n_total++; if (bus.act_cnt !== (CNT_ON ? 3'd7 : 3'd0) || bus.q !== 8'h00 || bus.changed !== 8'h01)
      $display("FAIL sat_cnt: got cnt=%0d q=%h chg=%h exp %0d/00/01", bus.act_cnt, bus.q, bus.changed,
               CNT_ON ? 7 : 0); else n_pass++;
    drive(0, 8'h00, 1, 2'b01, 8'h01, 8'h00, 1);
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL sat_clr_sb: got %h exp %h", got, e); else n_pass++;
    n_total++; if (bus.act_cnt !== (CNT_ON ? 3'd1 : 3'd0) || bus.changed !== 8'h01)
      $display("FAIL sat_clr: got cnt=%0d chg=%h exp %0d/01", bus.act_cnt, bus.changed, CNT_ON ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 80; c++) begin
      drive(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
      e = exp_q.pop_front();
      got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
      n_total++; if (got !== e || bus.qn !== ~bus.q)
        $display("FAIL rand_sb[%0d]: got %h qn=%h exp %h", c, got, bus.qn, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 8'hA5, 0, 2'b00, 8'h00, 8'h00, 0);
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL mid_pre_sb: got %h exp %h", got, e); else n_pass++;
    bus.load = 1; bus.en = 1; bus.chg_clr = 0; bus.load_data = 8'h3C;
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (bus.q !== 8'h00 || bus.qn !== 8'hFF)
      $display("FAIL mid_reset_q: got q=%h qn=%h exp 00/ff", bus.q, bus.qn); else n_pass++;
    n_total++; if (bus.changed !== 8'h00 || bus.act_cnt !== 3'd0 || bus.sr_err !== 1'b0)
      $display("FAIL mid_reset_flags: got chg=%h cnt=%0d err=%b", bus.changed, bus.act_cnt, bus.sr_err);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (bus.q !== 8'h00) $display("FAIL mid_reset_hold: got %h exp 00", bus.q); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 8'h00, 1, 2'b10, 8'h81, 8'h00, 0);
    e = exp_q.pop_front();
    got = {bus.q, bus.changed, bus.sr_err, bus.act_cnt};
    n_total++; if (got !== e) $display("FAIL mid_post_sb: got %h exp %h", got, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jk();
    test_priority();
    test_sr_err();
    test_saturation();
    test_random();
    test_reset_mid();
    n_total++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d left exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion exp finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jk_bank.md
# jk_bank

Parametrised bank of WIDTH independent JK-style storage bits sharing one clock, with a selectable per-bank function mode (JK, T, D, SR), parallel load, sticky per-bit change flags and an optional saturating activity counter. It generalises the single JK flip-flop cell into a reusable multi-bit state register for control and status logic. All state updates are synchronous to `clk`; only reset is asynchronous.

## Interface
- WIDTH, 8: number of storage bits (≥1).
- CNT_W, 8: width of the activity counter (≥1).

- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  function enable; when 0 `q` holds, unless `load`=1.
- mode  input  2  00 JK, 01 T, 10 D, 11 SR; applies to all bits.
- j  input  WIDTH  J / T / D / S input per bit, depending on `mode`.
- k  input  WIDTH  K / – / – / R input per bit; ignored in T and D modes.
- load  input  1  parallel load strobe.
- load_data  input  WIDTH  value written when `load`=1.
- chg_clr  input  1  clears `changed`, `act_cnt` and `sr_err`.
- q  output  WIDTH  stored state.
- qn  output  WIDTH  always bitwise ~`q`; never independently stored.
- changed  output  WIDTH  sticky: bit i set once `q[i]` has changed value since the last clear.
- sr_err  output  1  sticky: set when SR mode sees S=R=1 on any bit while `en`=1 and `load`=0.
- act_cnt  output  CNT_W  saturating count of cycles in which `q` changed.

## Operation
- Next-state priority per cycle: `load` > `en` > hold.
- `load`=1: `q` <= `load_data`, regardless of `en` and `mode`.
- `en`=1, `load`=0, per bit i:
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - T: `j[i]`=1 toggles, 0 holds.
  - D: `q[i]` <= `j[i]`.
  - SR: 10 set, 01 clear, 00 hold, 11 hold that bit and set `sr_err`.
- `en`=0, `load`=0: `q` holds. `mode` changes have no effect while `en`=0.
- `changed[i]` is set in any cycle where next `q[i]` != current `q[i]`, from load or function.
- `act_cnt` increments by 1 in any cycle where next `q` != current `q` (any bit). It holds at 2^CNT_W−1 and never wraps.
- `chg_clr`=1 zeros `changed`, `act_cnt` and `sr_err`. A change or error event in the same cycle wins:
  - `changed` gets only that cycle's changed bits.
  - `act_cnt` becomes 1 if `q` changed that cycle, else 0.
  - `sr_err` becomes 1 if SR 11 occurred that cycle, else 0.

## Timing
- Reset (`reset_n`=0, asynchronous assert): `q`=0, `qn`=all ones, `changed`=0, `sr_err`=0, `act_cnt`=0. These are held while `reset_n` is low.
- Reset deassertion is synchronised externally. The first state update occurs on the first rising edge with `reset_n`=1.
- Latency: inputs sampled at edge N appear on `q`/`changed`/`sr_err`/`act_cnt` after edge N, one cycle. `qn` tracks `q` combinationally with zero added cycles.
- Reset mid-operation clears all state immediately, regardless of `load`, `en` or `chg_clr`.
- No handshake: every input is sampled every cycle.

## Configuration
- JK_BANK_ACT_CNT_EN defined: `act_cnt` counter is implemented as described.
- Not defined: no counter flops; `act_cnt` is tied to 0. `changed` and `sr_err` are unaffected.

## Test plan
- Reset, WIDTH=8: drive `reset_n`=0 mid-run with `q`=8'hA5 -> `q`=8'h00, `qn`=8'hFF, `changed`=0, `act_cnt`=0 immediately, without waiting for a clock edge.
- JK mode: from `q`=8'h0F, apply `en`=1, `j`=8'hF0, `k`=8'h3C for one cycle. Per-bit JK gives `q`=8'hF3 (bits 2–3 cleared, 4–5 toggled, 6–7 set) -> `q`=8'hF3, `changed`=8'hFC, `act_cnt`=1.
- Priority: `load`=1, `load_data`=8'h5A, `en`=1, `mode`=JK, `j`=`k`=8'hFF -> `q`=8'h5A; then `en`=0 for 3 cycles -> `q` stays 8'h5A and `act_cnt` does not increment.
- SR error: `mode`=11, `q`=8'h00, `j`=8'h03, `k`=8'h01 -> bit0 holds 0, bit1 set; `q`=8'h02, `sr_err`=1. Next cycle `chg_clr`=1 with no event -> `sr_err`=0, `changed`=0, `act_cnt`=0.
- Saturation, CNT_W=3: T mode, `j`=8'h01 for 10 cycles -> `act_cnt` reaches 7 and stays 7. In the same cycle as a toggle, `chg_clr`=1 -> `act_cnt`=1, `changed`=8'h01.
- Macro off: repeat the saturation scenario without JK_BANK_ACT_CNT_EN -> `act_cnt`=0 throughout; `q`/`changed` identical to the macro-on run.
